// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer and the ALU:
// ALU control codes, FSM states, opcode/funct values and select fields.
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC     = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_IMM_EXEC = 4'd10,
    ST_IMM_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_REG     = 1'b1;
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // States whose exit edge completes an instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == ST_MEM_WB) || (s == ST_MEM_WR) || (s == ST_R_WB) ||
           (s == ST_BRANCH) || (s == ST_JUMP)   || (s == ST_IMM_WB);
  endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// R-type funct to ALU control code mapping; valid flags supported functs.
module alu_funct_decode
  import alu_seq_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_code,
  output logic       valid
);

  always_comb begin
    alu_code = ALU_AND;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_code = ALU_ADD;
      FN_SUB:  alu_code = ALU_SUB;
      FN_AND:  alu_code = ALU_AND;
      FN_OR:   alu_code = ALU_OR;
      FN_NOR:  alu_code = ALU_NOR;
      FN_SLT:  alu_code = ALU_SLT;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle MIPS control sequencer driving the ALU and datapath enables.
// ALU_SEQ_IMM_LOGIC_EN adds andi/ori/slti through the IMM_EXEC/IMM_WB path.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC + 4
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data memory read
// MEM_WB   | load result to register file (retire)
// MEM_WR   | data memory write (retire)
// EXEC     | R-type ALU operation
// R_WB     | R-type write back (retire)
// BRANCH   | beq compare, PC <= ALUOut when zero (retire)
// JUMP     | PC <= jump target (retire)
// IMM_EXEC | immediate ALU operation
// IMM_WB   | immediate write back (retire)
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic [5:0]           opcode_in,
  input  logic [5:0]           funct_in,
  input  logic                 zero_in,
  output logic [3:0]           alu_control_out,
  output logic                 alu_src_a_out,
  output logic [1:0]           alu_src_b_out,
  output logic [1:0]           pc_source_out,
  output logic                 pc_en_out,
  output logic                 ir_write_out,
  output logic                 mem_read_out,
  output logic                 mem_write_out,
  output logic                 i_or_d_out,
  output logic                 reg_dst_out,
  output logic                 mem_to_reg_out,
  output logic                 reg_write_out,
  output logic                 illegal_op_out,
  output logic [3:0]           state_out,
  output logic [WORD_SIZE-1:0] retired_count_out
);

  state_t               state_q;
  state_t               state_d;
  logic [WORD_SIZE-1:0] retired_q;
  logic [3:0]           funct_code;
  logic                 funct_valid;
  logic [3:0]           imm_code;
  logic                 pc_en_raw;
  logic                 ir_write_raw;
  logic                 mem_read_raw;
  logic                 mem_write_raw;
  logic                 reg_write_raw;

  alu_funct_decode u_funct_decode (
    .funct    (funct_in),
    .alu_code (funct_code),
    .valid    (funct_valid)
  );

  always_comb begin
    imm_code = ALU_ADD;
`ifdef ALU_SEQ_IMM_LOGIC_EN
    case (opcode_in)
      OP_ANDI: imm_code = ALU_AND;
      OP_ORI:  imm_code = ALU_OR;
      OP_SLTI: imm_code = ALU_SLT;
      default: imm_code = ALU_ADD;
    endcase
`endif
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= ST_FETCH;
    else             state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)                   retired_q <= '0;
    else if (is_retire_state(state_q)) retired_q <= retired_q + WORD_SIZE'(1);
  end

  always_comb begin
    state_d         = ST_FETCH;
    alu_control_out = ALU_AND;
    alu_src_a_out   = SRC_A_PC;
    alu_src_b_out   = SRC_B_REG;
    pc_source_out   = PC_SRC_ALU;
    pc_en_raw       = 1'b0;
    ir_write_raw    = 1'b0;
    mem_read_raw    = 1'b0;
    mem_write_raw   = 1'b0;
    reg_write_raw   = 1'b0;
    i_or_d_out      = 1'b0;
    reg_dst_out     = 1'b0;
    mem_to_reg_out  = 1'b0;
    illegal_op_out  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_raw    = 1'b1;
        ir_write_raw    = 1'b1;
        pc_en_raw       = 1'b1;
        alu_src_b_out   = SRC_B_FOUR;
        alu_control_out = ALU_ADD;
        state_d         = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b_out   = SRC_B_IMM_SH2;
        alu_control_out = ALU_ADD;
        case (opcode_in)
          OP_RTYPE: begin
            if (funct_valid) state_d = ST_EXEC;
            else             illegal_op_out = 1'b1;
          end
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_IMM_EXEC;
`ifdef ALU_SEQ_IMM_LOGIC_EN
          OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_IMM_EXEC;
`endif
          default:      illegal_op_out = 1'b1;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a_out   = SRC_A_REG;
        alu_src_b_out   = SRC_B_IMM;
        alu_control_out = ALU_ADD;
        state_d         = (opcode_in == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read_raw = 1'b1;
        i_or_d_out   = 1'b1;
        state_d      = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write_raw  = 1'b1;
        mem_to_reg_out = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_raw = 1'b1;
        i_or_d_out    = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a_out   = SRC_A_REG;
        alu_control_out = funct_code;
        state_d         = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write_raw = 1'b1;
        reg_dst_out   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_out   = SRC_A_REG;
        alu_control_out = ALU_SUB;
        pc_source_out   = PC_SRC_ALUOUT;
        pc_en_raw       = zero_in;
      end
      ST_JUMP: begin
        pc_en_raw     = 1'b1;
        pc_source_out = PC_SRC_JUMP;
      end
      ST_IMM_EXEC: begin
        alu_src_a_out   = SRC_A_REG;
        alu_src_b_out   = SRC_B_IMM;
        alu_control_out = imm_code;
        state_d         = ST_IMM_WB;
      end
      ST_IMM_WB: reg_write_raw = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset holds the FETCH selects but must not let FETCH strobe memory or PC.
  assign pc_en_out         = pc_en_raw     & reset_n_in;
  assign ir_write_out      = ir_write_raw  & reset_n_in;
  assign mem_read_out      = mem_read_raw  & reset_n_in;
  assign mem_write_out     = mem_write_raw & reset_n_in;
  assign reg_write_out     = reg_write_raw & reset_n_in;
  assign state_out         = state_q;
  assign retired_count_out = retired_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl: per-instruction state walks,
// control outputs, branch resolution, illegal ops, mid-instruction reset, wrap.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        zero = 1'b0;
  logic [3:0]  alu_control;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_source;
  logic        pc_en, ir_write, mem_read, mem_write, i_or_d;
  logic        reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0]  state;
  logic [31:0] count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 32'd0;
  logic rw_seen = 1'b0;
  logic watch_rw = 1'b0;

  wire [7:0] ctl = {pc_en, ir_write, mem_read, mem_write, i_or_d, reg_dst, mem_to_reg, reg_write};
  wire [8:0] sel = {alu_src_a, alu_src_b, pc_source, alu_control};

  localparam logic [8:0] SEL_FETCH  = 9'b0_01_00_0010;
  localparam logic [8:0] SEL_DECODE = 9'b0_11_00_0010;
  localparam logic [8:0] SEL_MADDR  = 9'b1_10_00_0010;
  localparam logic [7:0] CTL_FETCH  = 8'b1110_0000;

  alu_seq_ctrl #(.WORD_SIZE(32)) dut (
    .clk_in(clk), .reset_n_in(rst_n), .opcode_in(opcode), .funct_in(funct), .zero_in(zero),
    .alu_control_out(alu_control), .alu_src_a_out(alu_src_a), .alu_src_b_out(alu_src_b),
    .pc_source_out(pc_source), .pc_en_out(pc_en), .ir_write_out(ir_write),
    .mem_read_out(mem_read), .mem_write_out(mem_write), .i_or_d_out(i_or_d),
    .reg_dst_out(reg_dst), .mem_to_reg_out(mem_to_reg), .reg_write_out(reg_write),
    .illegal_op_out(illegal_op), .state_out(state), .retired_count_out(count)
  );

  always #5 clk = ~clk;

  always @(reg_write) if (watch_rw && reg_write) rw_seen = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_end(input string name);
    checks++;
    if (state !== 4'd0 || count !== exp_count) begin
      errors++;
      $display("FAIL %s_end state=%0d count=%0d required state=0 count=%0d", name, state, count, exp_count);
    end
  endtask

  // Walks n states comparing state, control enables and selects each cycle.
  task automatic walk(input string name, input int n, input logic [3:0] st [6],
                      input logic [7:0] ct [6], input logic [8:0] sl [6]);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL %s[%0d] state got %0d required %0d", name, i, state, st[i]);
      end
      checks++;
      if (ctl !== ct[i]) begin
        errors++;
        $display("FAIL %s[%0d] enables got %b required %b", name, i, ctl, ct[i]);
      end
      checks++;
      if (sel !== sl[i]) begin
        errors++;
        $display("FAIL %s[%0d] selects got %b required %b", name, i, sel, sl[i]);
      end
      step();
    end
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (state !== 4'd0 || count !== 32'd0 || ctl !== 8'h00 || sel !== SEL_FETCH) begin
        errors++;
        $display("FAIL reset[%0d] state=%0d count=%0d ctl=%b sel=%b required 0 0 00000000 %b",
                 i, state, count, ctl, sel, SEL_FETCH);
      end
      step();
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || ctl !== CTL_FETCH) begin
      errors++;
      $display("FAIL reset_release state=%0d ctl=%b required 0 %b", state, ctl, CTL_FETCH);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [3:0] cd [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
    for (int k = 0; k < 6; k++) begin
      opcode = 6'h00;
      funct  = fn[k];
      walk($sformatf("rtype_%h", fn[k]), 4, '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0},
           '{CTL_FETCH, 8'h00, 8'h00, 8'b0000_0101, 8'h00, 8'h00},
           '{SEL_FETCH, SEL_DECODE, {5'b1_00_00, cd[k]}, 9'h000, 9'h000, 9'h000});
      exp_count++;
      check_end("rtype");
    end
  endtask

  task automatic test_lw_sw();
    opcode = 6'h23;
    walk("lw", 5, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0},
         '{CTL_FETCH, 8'h00, 8'h00, 8'b0010_1000, 8'b0000_0011, 8'h00},
         '{SEL_FETCH, SEL_DECODE, SEL_MADDR, 9'h000, 9'h000, 9'h000});
    exp_count++;
    check_end("lw");
    opcode = 6'h2B;
    walk("sw", 4, '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0},
         '{CTL_FETCH, 8'h00, 8'h00, 8'b0001_1000, 8'h00, 8'h00},
         '{SEL_FETCH, SEL_DECODE, SEL_MADDR, 9'h000, 9'h000, 9'h000});
    exp_count++;
    check_end("sw");
  endtask

  task automatic test_branch_jump();
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'h04;
      zero   = z[0];
      walk($sformatf("beq_z%0d", z), 3, '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0},
           '{CTL_FETCH, 8'h00, {z[0], 7'b0}, 8'h00, 8'h00, 8'h00},
           '{SEL_FETCH, SEL_DECODE, 9'b1_00_01_0110, 9'h000, 9'h000, 9'h000});
      exp_count++;
      check_end("beq");
    end
    zero   = 1'b0;
    opcode = 6'h02;
    walk("j", 3, '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0},
         '{CTL_FETCH, 8'h00, 8'b1000_0000, 8'h00, 8'h00, 8'h00},
         '{SEL_FETCH, SEL_DECODE, 9'b0_00_10_0000, 9'h000, 9'h000, 9'h000});
    exp_count++;
    check_end("j");
  endtask

  task automatic test_imm();
    opcode = 6'h08;
    walk("addi", 4, '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0},
         '{CTL_FETCH, 8'h00, 8'h00, 8'b0000_0001, 8'h00, 8'h00},
         '{SEL_FETCH, SEL_DECODE, 9'b1_10_00_0010, 9'h000, 9'h000, 9'h000});
    exp_count++;
    check_end("addi");
    opcode = 6'h0D;
`ifdef ALU_SEQ_IMM_LOGIC_EN
    walk("ori", 4, '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0},
         '{CTL_FETCH, 8'h00, 8'h00, 8'b0000_0001, 8'h00, 8'h00},
         '{SEL_FETCH, SEL_DECODE, 9'b1_10_00_0001, 9'h000, 9'h000, 9'h000});
    exp_count++;
`else
    step();
    checks++;
    if (state !== 4'd1 || illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL ori_illegal state=%0d illegal=%b required 1 1", state, illegal_op);
    end
    step();
`endif
    check_end("ori");
  endtask

  task automatic test_illegal();
    logic [5:0] op [2] = '{6'h3F, 6'h00};
    for (int k = 0; k < 2; k++) begin
      opcode = op[k];
      funct  = 6'h00;
      checks++;
      if (illegal_op !== 1'b0) begin
        errors++;
        $display("FAIL illegal_fetch[%0d] illegal got %b required 0", k, illegal_op);
      end
      step();
      checks++;
      if (state !== 4'd1 || illegal_op !== 1'b1 || ctl !== 8'h00) begin
        errors++;
        $display("FAIL illegal_decode[%0d] state=%0d illegal=%b ctl=%b required 1 1 00000000",
                 k, state, illegal_op, ctl);
      end
      step();
      check_end("illegal");
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'h23;
    step(); step(); step();
    checks++;
    if (state !== 4'd3) begin
      errors++;
      $display("FAIL midrst_pre state got %0d required 3", state);
    end
    watch_rw = 1'b1;
    rw_seen  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || count !== 32'd0 || ctl !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async state=%0d count=%0d ctl=%b required 0 0 00000000", state, count, ctl);
    end
    step(); step();
    checks++;
    if (rw_seen !== 1'b0 || state !== 4'd0) begin
      errors++;
      $display("FAIL midrst_hold reg_write_seen=%b state=%0d required 0 0", rw_seen, state);
    end
    watch_rw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 32'd0;
    opcode = 6'h02;
    step();
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL midrst_first_edge state got %0d required 1", state);
    end
    step(); step();
    exp_count++;
    check_end("midrst_j");
  endtask

  task automatic test_wrap();
    opcode = 6'h02;
    step(); step();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    #1;
    checks++;
    if (state !== 4'd9 || count !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preload state=%0d count=%h required 9 ffffffff", state, count);
    end
    step();
    exp_count = 32'd0;
    check_end("wrap");
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_rtype();
        test_lw_sw();
        test_branch_jump();
        test_imm();
        test_illegal();
        test_reset_mid();
        test_wrap();
      end
      begin
        #50000;
        errors++;
        $display("FAIL timeout bench did not complete within 50000 time units");
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
